// File: rtl/rmt_meta_alu.sv
// RMT metadata-action ALU (ALU3): MCAST / DISCARD on the metadata vector.
// ALU3_ZERO_MCAST_DROP_EN: an empty MCAST map also raises the drop flag.
module rmt_meta_alu #(
  parameter int STAGE      = 0,
  parameter int ACTION_LEN = 25,
  parameter int META_LEN   = 256,
  parameter int COMP_LEN   = 100
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [META_LEN+COMP_LEN-1:0] comp_meta_data_in,
  input  logic                         comp_meta_data_valid_in,
  input  logic [ACTION_LEN-1:0]        action_in,
  input  logic                         action_valid_in,
  output logic [META_LEN+COMP_LEN-1:0] comp_meta_data_out,
  output logic                         comp_meta_data_valid_out
);

  localparam int DW      = META_LEN + COMP_LEN;
  localparam int DST_LO  = COMP_LEN + 24;
  localparam int DROP_B  = COMP_LEN + 128;

  localparam logic [3:0] OP_MCAST   = 4'b1100;
  localparam logic [3:0] OP_DISCARD = 4'b1101;

  logic [3:0]    op;
  logic [7:0]    mcast_map;
  logic          discard_bit;
  logic          is_mcast;
  logic          is_discard;
  logic [DW-1:0] nxt;

  // Reserved action bits and the stage index carry no function.
  logic unused_bits;
  assign unused_bits = ^action_in[11:0]
                     ^ (STAGE != 0);

  assign op          = action_in[24:21];
  assign mcast_map   = action_in[20:13];
  assign discard_bit = action_in[12];
  assign is_mcast    = (op == OP_MCAST);
  assign is_discard  = (op == OP_DISCARD);

  always_comb begin
    nxt = comp_meta_data_in;
    if (action_valid_in) begin
      unique case (1'b1)
        is_mcast: begin
          nxt[DST_LO +: 8] = mcast_map;
`ifdef ALU3_ZERO_MCAST_DROP_EN
          if (mcast_map == 8'h00)
            nxt[DROP_B] = 1'b1;
`endif
        end
        is_discard: nxt[DROP_B] = discard_bit;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_meta_data_out       <= '0;
      comp_meta_data_valid_out <= 1'b0;
    end else begin
      comp_meta_data_valid_out <= comp_meta_data_valid_in;
      if (comp_meta_data_valid_in)
        comp_meta_data_out <= nxt;
    end
  end

endmodule

// File: tb/tb_rmt_meta_alu.sv
// Scoreboarded random + directed bench for rmt_meta_alu.
// Honours ALU3_ZERO_MCAST_DROP_EN in its reference model.
module tb_rmt_meta_alu;

  localparam int META = 256;
  localparam int COMP = 100;
  localparam int DW   = META + COMP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] d_in = '0;
  logic          dv_in = 1'b0;
  logic [24:0]   a_in = '0;
  logic          av_in = 1'b0;
  logic [DW-1:0] d_out;
  logic          dv_out;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int            due;
    logic [DW-1:0] exp;
  } exp_t;
  exp_t q[$];

  logic [DW-1:0] last = '0;

  rmt_meta_alu #(
    .STAGE(0), .ACTION_LEN(25),
    .META_LEN(META), .COMP_LEN(COMP)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .comp_meta_data_in       (d_in),
    .comp_meta_data_valid_in (dv_in),
    .action_in               (a_in),
    .action_valid_in         (av_in),
    .comp_meta_data_out      (d_out),
    .comp_meta_data_valid_out(dv_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(
      input logic [DW-1:0] d,
      input logic [24:0]   a,
      input logic          av);
    logic [META-1:0] meta;
    logic [COMP-1:0] comp;
    meta = d[DW-1:COMP];
    comp = d[COMP-1:0];
    if (av && a[24:21] == 4'hC) begin
      meta[31:24] = a[20:13];
`ifdef ALU3_ZERO_MCAST_DROP_EN
      if (a[20:13] == 8'h00) meta[128] = 1'b1;
`endif
    end else if (av && a[24:21] == 4'hD) begin
      meta[128] = a[12];
    end
    return {meta, comp};
  endfunction

  function automatic logic [24:0] act(
      input logic [3:0] op,
      input logic [7:0] map,
      input logic       db);
    logic [11:0] rsv;
    rsv = 12'($urandom);
    return {op, map, db, rsv};
  endfunction

  function automatic logic [DW-1:0] rnd_vec();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DW; i += 32)
      v = (v << 32) | DW'($urandom);
    return v;
  endfunction

  task automatic drive(input logic [DW-1:0] d,
                       input logic          dv,
                       input logic [24:0]   a,
                       input logic          av);
    exp_t e;
    @(negedge clk);
    d_in  = d;
    dv_in = dv;
    a_in  = a;
    av_in = av;
    if (dv) begin
      e.due = cyc + 1;
      e.exp = model(d, a, av);
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(rnd_vec(), 1'b0, 25'($urandom), 1'b0);
  endtask

  // Monitor: pops on every valid_out, checks timing and data.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        last = '0;
      end else begin
        if (q.size() > 0 && q[0].due < cyc) begin
          e = q.pop_front();
          chk("missing_output", '0, DW'(1));
        end
        if (dv_out) begin
          if (q.size() == 0) begin
            chk("spurious_valid", DW'(1), '0);
          end else begin
            e = q.pop_front();
            chk("latency", DW'(cyc), DW'(e.due));
            chk("data_out", d_out, e.exp);
          end
          last = d_out;
        end else begin
          chk("hold", d_out, last);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] v;
    logic [3:0]    op;
    logic [7:0]    mp;
    int            r;

    #1;
    chk("rst_valid", DW'(dv_out), '0);
    chk("rst_data", d_out, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // MCAST FF on zero data
    drive('0, 1'b1, act(4'hC, 8'hFF, 1'b0), 1'b1);
    idle(2);
    // DISCARD set then clear
    drive('0, 1'b1, act(4'hD, 8'h00, 1'b1), 1'b1);
    v = '0;
    v[COMP+128] = 1'b1;
    drive(v, 1'b1, act(4'hD, 8'h00, 1'b0), 1'b1);
    idle(1);
    // pass-through: no action, NOP op
    drive(rnd_vec(), 1'b1, act(4'hC, 8'h3C, 1'b1), 1'b0);
    drive(rnd_vec(), 1'b1, act(4'h0, 8'h3C, 1'b1), 1'b1);
    // back-to-back, then action without data
    drive('0, 1'b1, act(4'hC, 8'hA5, 1'b0), 1'b1);
    drive('0, 1'b1, act(4'hD, 8'h00, 1'b1), 1'b1);
    drive(rnd_vec(), 1'b0, act(4'hC, 8'h11, 1'b1), 1'b1);
    idle(2);
    // empty multicast map
    drive('0, 1'b1, act(4'hC, 8'h00, 1'b0), 1'b1);
    drive(rnd_vec(), 1'b1, act(4'hC, 8'h00, 1'b0), 1'b1);
    idle(2);

    // Async reset mid-cycle drops the in-flight vector
    drive(rnd_vec(), 1'b1, act(4'hC, 8'h5A, 1'b0), 1'b1);
    drive(rnd_vec(), 1'b1, act(4'hD, 8'h00, 1'b1), 1'b1);
    #2;
    rst   = 1'b1;
    dv_in = 1'b0;
    av_in = 1'b0;
    q.delete();
    #1;
    chk("async_rst_valid", DW'(dv_out), '0);
    chk("async_rst_data", d_out, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 3);
      op = (r == 0) ? 4'hC :
           (r == 1) ? 4'hD : 4'($urandom);
      mp = ($urandom_range(0, 7) == 0) ? 8'h00
                                       : 8'($urandom);
      drive(rnd_vec(), $urandom_range(0, 3) != 0,
            act(op, mp, 1'($urandom)),
            $urandom_range(0, 3) != 0);
    end
    idle(4);
    chk("queue_drained", DW'(q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
